// File: rtl/strip_pixel_loader.sv
// Host byte stream to per-strip pixel RAM write port: assembles 3-byte pixels, one write per pixel.
// Define STRIP_PIXEL_LOADER_GAMMA_EN to add a gamma-2.2 ROM stage (latency 2 instead of 1).
module strip_pixel_loader #(
  parameter int unsigned LED_COUNT   = 240,
  parameter int unsigned COLOR_ORDER = 0
) (
  input  logic       pixel_clk_i,
  input  logic       rst_i,
  input  logic       frame_start_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic [7:0] pixel_r_o,
  output logic [7:0] pixel_g_o,
  output logic [7:0] pixel_b_o,
  output logic [8:0] led_address_o,
  output logic       led_address_valid_o,
  output logic       frame_done_o,
  output logic       overflow_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [8:0] LastAddr = 9'(LED_COUNT - 1);

  state_e     r_state;
  logic [1:0] r_phase;
  logic [8:0] r_addr;
  logic [7:0] r_hold0;
  logic [7:0] r_hold1;
  logic [7:0] r_pix_r;
  logic [7:0] r_pix_g;
  logic [7:0] r_pix_b;
  logic [8:0] r_led_addr;
  logic       r_wr;
  logic       r_done;
  logic       r_overflow;

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_phase    <= 2'd0;
      r_addr     <= 9'd0;
      r_hold0    <= 8'd0;
      r_hold1    <= 8'd0;
      r_pix_r    <= 8'd0;
      r_pix_g    <= 8'd0;
      r_pix_b    <= 8'd0;
      r_led_addr <= 9'd0;
      r_wr       <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      if (frame_start_i) begin
        // Start wins over everything; a coincident byte opens the new frame.
        r_state    <= StLoad;
        r_addr     <= 9'd0;
        r_overflow <= 1'b0;
        if (byte_valid_i) begin
          r_hold0 <= byte_i;
          r_phase <= 2'd1;
        end else begin
          r_phase <= 2'd0;
        end
      end else begin
        unique case (r_state)
          StIdle: ;
          StLoad: begin
            if (byte_valid_i) begin
              case (r_phase)
                2'd0: begin
                  r_hold0 <= byte_i;
                  r_phase <= 2'd1;
                end
                2'd1: begin
                  r_hold1 <= byte_i;
                  r_phase <= 2'd2;
                end
                default: begin
                  r_phase    <= 2'd0;
                  r_wr       <= 1'b1;
                  r_led_addr <= r_addr;
                  r_pix_b    <= byte_i;
                  if (COLOR_ORDER == 0) begin
                    r_pix_r <= r_hold0;
                    r_pix_g <= r_hold1;
                  end else begin
                    r_pix_r <= r_hold1;
                    r_pix_g <= r_hold0;
                  end
                  if (r_addr == LastAddr) begin
                    r_done  <= 1'b1;
                    r_state <= StDone;
                  end else begin
                    r_addr <= r_addr + 9'd1;
                  end
                end
              endcase
            end
          end
          StDone: begin
            if (byte_valid_i) r_overflow <= 1'b1;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign overflow_o = r_overflow;
  assign busy_o     = (r_state == StLoad);

`ifdef STRIP_PIXEL_LOADER_GAMMA_EN
  // Integer fit of x^2.2 as x^2*(0.8+0.2x), exact at both ends (0->0, 255->255).
  function automatic logic [2047:0] gen_gamma_lut();
    logic [2047:0]   lut;
    longint unsigned x;
    longint unsigned y;
    lut = '0;
    for (int i = 0; i < 256; i++) begin
      x = longint'(i);
      y = (x * x * (64'd52020 + 64'd51 * x) + 64'd8290687) / 64'd16581375;
      lut[i*8 +: 8] = y[7:0];
    end
    return lut;
  endfunction

  localparam logic [2047:0] GammaLut = gen_gamma_lut();

  logic [7:0] r_g_r;
  logic [7:0] r_g_g;
  logic [7:0] r_g_b;
  logic [8:0] r_g_addr;
  logic       r_g_wr;
  logic       r_g_done;

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_g_r    <= 8'd0;
      r_g_g    <= 8'd0;
      r_g_b    <= 8'd0;
      r_g_addr <= 9'd0;
      r_g_wr   <= 1'b0;
      r_g_done <= 1'b0;
    end else begin
      r_g_r    <= GammaLut[{r_pix_r, 3'b000} +: 8];
      r_g_g    <= GammaLut[{r_pix_g, 3'b000} +: 8];
      r_g_b    <= GammaLut[{r_pix_b, 3'b000} +: 8];
      r_g_addr <= r_led_addr;
      r_g_wr   <= r_wr;
      r_g_done <= r_done;
    end
  end

  assign pixel_r_o           = r_g_r;
  assign pixel_g_o           = r_g_g;
  assign pixel_b_o           = r_g_b;
  assign led_address_o       = r_g_addr;
  assign led_address_valid_o = r_g_wr;
  assign frame_done_o        = r_g_done;
`else
  assign pixel_r_o           = r_pix_r;
  assign pixel_g_o           = r_pix_g;
  assign pixel_b_o           = r_pix_b;
  assign led_address_o       = r_led_addr;
  assign led_address_valid_o = r_wr;
  assign frame_done_o        = r_done;
`endif

endmodule

// File: tb/tb_strip_pixel_loader.sv
// Directed bench: two loaders (COLOR_ORDER 0 and 1, LED_COUNT 4) fed the same byte stream.
module tb_strip_pixel_loader;

  logic       clk;
  logic       rst;
  logic       fs;
  logic [7:0] bt;
  logic       bv;

  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic [8:0] a0, a1;
  logic       v0, v1, d0, d1, o0, o1, y0, y1;

  int checks = 0;
  int errors = 0;

  strip_pixel_loader #(.LED_COUNT(4), .COLOR_ORDER(0)) u_dut0 (
    .pixel_clk_i(clk), .rst_i(rst), .frame_start_i(fs), .byte_i(bt), .byte_valid_i(bv),
    .pixel_r_o(r0), .pixel_g_o(g0), .pixel_b_o(b0), .led_address_o(a0),
    .led_address_valid_o(v0), .frame_done_o(d0), .overflow_o(o0), .busy_o(y0)
  );

  strip_pixel_loader #(.LED_COUNT(4), .COLOR_ORDER(1)) u_dut1 (
    .pixel_clk_i(clk), .rst_i(rst), .frame_start_i(fs), .byte_i(bt), .byte_valid_i(bv),
    .pixel_r_o(r1), .pixel_g_o(g1), .pixel_b_o(b1), .led_address_o(a1),
    .led_address_valid_o(v1), .frame_done_o(d1), .overflow_o(o1), .busy_o(y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present inputs for one cycle; returns 1 time unit after the capturing edge.
  task automatic drive(input logic f, input logic v, input logic [7:0] b);
    fs = f;
    bv = v;
    bt = b;
    @(posedge clk);
    #1;
    fs = 1'b0;
    bv = 1'b0;
    bt = 8'h00;
  endtask

  task automatic chk_strobe(input string tag, input logic [8:0] addr, input logic [7:0] pr,
                            input logic [7:0] pg, input logic [7:0] pb, input logic done);
    chk({tag, "_v0"}, v0, 1'b1);
    chk({tag, "_a0"}, a0, addr);
    chk({tag, "_rgb0"}, {r0, g0, b0}, {pr, pg, pb});
    chk({tag, "_rgb1"}, {r1, g1, b1}, {pg, pr, pb});
    chk({tag, "_d0"}, d0, done);
  endtask

  initial begin
    rst = 1'b1;
    fs  = 1'b0;
    bv  = 1'b0;
    bt  = 8'h00;
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    #1;
    chk("rst_outs", {v0, d0, o0, y0, a0, r0, g0, b0}, '0);
    chk("rst_outs1", {v1, d1, o1, y1, a1}, '0);

    // Bytes in IDLE are ignored and do not flag overflow
    drive(1'b0, 1'b1, 8'hAA);
    drive(1'b0, 1'b1, 8'hBB);
    drive(1'b0, 1'b1, 8'hCC);
    chk("idle_ignore", {v0, o0, y0}, 3'b000);

    drive(1'b1, 1'b0, 8'h00);
    chk("busy_load", y0, 1'b1);
    drive(1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b1, 8'h22);
    chk("no_strobe_ph2", v0, 1'b0);
    drive(1'b0, 1'b1, 8'h33);
    chk_strobe("px0", 9'd0, 8'h11, 8'h22, 8'h33, 1'b0);
    chk("busy_px0", y0, 1'b1);
    drive(1'b0, 1'b0, 8'h00);
    chk("strobe_1cyc", v0, 1'b0);
    chk("hold", {a0, r0, g0, b0}, {9'd0, 8'h11, 8'h22, 8'h33});

    // Pixels 1..3 back-to-back, one strobe every third cycle
    for (int p = 1; p <= 3; p++) begin
      drive(1'b0, 1'b1, 8'(p * 16 + 1));
      chk($sformatf("bb%0d_gap1", p), v0, 1'b0);
      drive(1'b0, 1'b1, 8'(p * 16 + 2));
      chk($sformatf("bb%0d_gap2", p), v0, 1'b0);
      drive(1'b0, 1'b1, 8'(p * 16 + 3));
      chk_strobe($sformatf("bb%0d", p), 9'(p), 8'(p * 16 + 1), 8'(p * 16 + 2), 8'(p * 16 + 3),
                 p == 3);
    end
    chk("done_busy", {y0, o0}, 2'b00);

    drive(1'b0, 1'b1, 8'hE1);
    chk("ovf_set", {v0, d0, o0}, 3'b001);
    drive(1'b0, 1'b1, 8'hE2);
    chk("ovf_sticky", {v0, o0, o1}, 3'b011);

    drive(1'b1, 1'b0, 8'h00);
    chk("ovf_clr", {o0, y0}, 2'b01);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h02);
    drive(1'b0, 1'b1, 8'h03);
    chk_strobe("restart", 9'd0, 8'h01, 8'h02, 8'h03, 1'b0);

    // Partial pixel at address 1 abandoned by a start carrying its own first byte
    drive(1'b0, 1'b1, 8'hA1);
    drive(1'b0, 1'b1, 8'hA2);
    drive(1'b1, 1'b1, 8'h55);
    chk("partial_drop", v0, 1'b0);
    drive(1'b0, 1'b1, 8'h66);
    chk("partial_gap", v0, 1'b0);
    drive(1'b0, 1'b1, 8'h77);
    chk_strobe("coinc", 9'd0, 8'h55, 8'h66, 8'h77, 1'b0);

    drive(1'b0, 1'b1, 8'h0A);
    drive(1'b0, 1'b1, 8'h0B);
    drive(1'b0, 1'b1, 8'h0C);
    chk_strobe("px1b", 9'd1, 8'h0A, 8'h0B, 8'h0C, 1'b0);

    // Asynchronous reset while the strobe is high
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {v0, y0, a0, r0, g0, b0}, '0);
    #2 rst = 1'b0;

    drive(1'b0, 1'b1, 8'h21);
    drive(1'b0, 1'b1, 8'h22);
    drive(1'b0, 1'b1, 8'h23);
    chk("post_rst_ignore", {v0, y0, o0}, 3'b000);
    drive(1'b1, 1'b1, 8'h31);
    drive(1'b0, 1'b1, 8'h32);
    drive(1'b0, 1'b1, 8'h33);
    chk_strobe("post_rst", 9'd0, 8'h31, 8'h32, 8'h33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/strip_pixel_loader.md
Name: strip_pixel_loader

Overview:
Upstream feeder for the per-strip pixel RAM wrapper. Accepts a host byte stream (one colour byte per beat, framed by a start pulse) on the pixel clock. Assembles bytes into 24-bit pixels and emits one RAM write per pixel (r/g/b, 9-bit LED address, write strobe). Tracks frame completion and flags overrun bytes.

Parameters:
LED_COUNT, 240, LEDs on the strip; legal range 1..512; address wraps never, excess is overrun.
COLOR_ORDER, 0, host byte order within a pixel: 0 = R,G,B; 1 = G,R,B.

Ports:
pixel_clk_i  input  1  sole clock; all logic rising-edge.
rst_i  input  1  asynchronous, active-high reset.
frame_start_i  input  1  single-cycle pulse: begin new frame at address 0.
byte_i  input  8  host colour byte.
byte_valid_i  input  1  byte_i valid this cycle; always accepted (no backpressure).
pixel_r_o  output  8  red of assembled pixel.
pixel_g_o  output  8  green of assembled pixel.
pixel_b_o  output  8  blue of assembled pixel.
led_address_o  output  9  RAM write address of assembled pixel.
led_address_valid_o  output  1  one-cycle write strobe for pixel_*_o/led_address_o.
frame_done_o  output  1  one-cycle pulse when pixel LED_COUNT-1 is written.
overflow_o  output  1  sticky: bytes received after frame complete; cleared by frame_start_i.
busy_o  output  1  high in LOAD state.

Behaviour:
- Reset (async assert, sync-released use): state IDLE, byte phase 0, address 0, all outputs 0.
- States: IDLE, LOAD, DONE.
  - IDLE: bytes ignored (no overflow). frame_start_i -> LOAD.
  - LOAD: byte phase counter 0..2 captures bytes into holding regs per COLOR_ORDER. On phase-2 byte: register pixel + current address to outputs, pulse led_address_valid_o next cycle (latency 1 cycle from third byte), phase -> 0, address +1. If written address == LED_COUNT-1: pulse frame_done_o same cycle as strobe, -> DONE.
  - DONE: every byte_valid_i sets overflow_o; byte dropped, no write. frame_start_i -> LOAD.
- frame_start_i in any state: address 0, phase 0, overflow_o cleared, state LOAD; partial pixel (phase 1 or 2) discarded, no write.
- frame_start_i with byte_valid_i same cycle: start wins, byte taken as phase-0 byte of new frame.
- Back-to-back bytes every cycle supported: sustained one pixel strobe per 3 cycles.
- Address width 9 bits; counter never exceeds LED_COUNT-1; no wrap.
- pixel_*_o and led_address_o hold last written value between strobes.
- Reset mid-frame: immediate return to IDLE, pending pixel lost, strobe deasserts asynchronously.

Optional Feature:
STRIP_PIXEL_LOADER_GAMMA_EN: when defined, each assembled channel passes through a 256x8 gamma-2.2 lookup (synchronous ROM, initialised from a constant table) before output; strobe, address, frame_done_o delayed by one extra cycle (latency 2) to stay aligned. When undefined, bytes pass unmodified with latency 1 and no ROM inferred. Gamma ROM maps 0->0 and 255->255.

Test Plan:
- Reset, LED_COUNT=4, COLOR_ORDER=0: frame_start, bytes 11,22,33 -> one cycle later strobe with r=11,g=22,b=33, addr=0; busy_o=1.
- COLOR_ORDER=1, bytes 11,22,33 -> r=22,g=11,b=33.
- LED_COUNT=4, 12 bytes back-to-back -> strobes at addr 0..3 every 3 cycles; frame_done_o with addr 3 strobe; state DONE, busy_o=0.
- After done, 2 extra bytes -> no strobe, overflow_o=1; then frame_start -> overflow_o=0, next triplet writes addr 0.
- Frame_start after 2 bytes of pixel 1, coincident with byte 55, then 66,77 -> no write of partial pixel; strobe addr 0 r=55,g=66,b=77.
- rst_i asserted mid-pixel -> outputs 0 immediately; bytes before frame_start ignored; with GAMMA_EN defined, byte 255/0 -> 255/0 at latency 2.
